skid_buffer: RTL

SKID_BUFFER -- requirements
Module: skid_buffer

---
 rtl/skid_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered ready/valid pipeline stage that breaks the
// combinational ready path while keeping full throughput.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Encoding chosen so bit 0 is the main valid flag and bit 1 the skid valid flag.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_vld;
    logic             skid_vld;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign main_vld  = state[0];
    assign skid_vld  = state[1];

    assign in_ready  = ~skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_data;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    next_state   = ONE;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b11: load_main_in = 1'b1;
                    2'b10: begin
                        load_skid  = 1'b1;
                        next_state = FULL;
                    end
                    2'b01:   next_state = EMPTY;
                    default: next_state = ONE;
                endcase
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    next_state     = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule
